// File: rtl/regwrite_hazard_ctrl.sv
// Four-deep in-flight write table with RAW stall and operand-forward control.
// Optional feature: define HAZARD_FWD_EN to forward from ages 3/4 instead of stalling.
module regwrite_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       IssueValid,
  input  logic       IssueRegWrt,
  input  logic [1:0] IssueRegWData,
  input  logic [4:0] IssueRd,
  input  logic [4:0] Rn,
  input  logic [4:0] Rm,
  input  logic       RnUse,
  input  logic       RmUse,
  input  logic       Flush,
  output logic       Stall,
  output logic [1:0] FwdA,
  output logic [1:0] FwdB,
  output logic       WbRegWrt,
  output logic [1:0] WbRegWData,
  output logic [4:0] WbRd,
  output logic [7:0] StallCnt
);

  typedef struct packed {
    logic       wrt;
    logic [1:0] wd;
    logic [4:0] rd;
  } ent_t;

  // index 0 holds age 1, index 3 holds age 4
  ent_t [3:0] tbl_q, tbl_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mtch_a, mtch_b;
  logic [2:0] age_a, age_b;
  logic       st_a, st_b;

  function automatic logic [2:0] youngest(input logic [3:0] m);
    logic [2:0] a;
    a = 3'd0;
    priority case (1'b1)
      m[0]:    a = 3'd1;
      m[1]:    a = 3'd2;
      m[2]:    a = 3'd3;
      m[3]:    a = 3'd4;
      default: a = 3'd0;
    endcase
    return a;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mtch_a[i] = RnUse && tbl_q[i].wrt &&
                  (tbl_q[i].rd != 5'd31) && (tbl_q[i].rd == Rn);
      mtch_b[i] = RmUse && tbl_q[i].wrt &&
                  (tbl_q[i].rd != 5'd31) && (tbl_q[i].rd == Rm);
    end
    age_a = youngest(mtch_a);
    age_b = youngest(mtch_b);
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    st_a  = (age_a == 3'd1) || (age_a == 3'd2);
    st_b  = (age_b == 3'd1) || (age_b == 3'd2);
    Stall = IssueValid && !Flush && (st_a || st_b);
    FwdA  = 2'd0;
    FwdB  = 2'd0;
    if (IssueValid && !Stall) begin
      if (age_a == 3'd3) FwdA = 2'd1;
      if (age_a == 3'd4) FwdA = 2'd2;
      if (age_b == 3'd3) FwdB = 2'd1;
      if (age_b == 3'd4) FwdB = 2'd2;
    end
  end
`else
  always_comb begin
    st_a  = (age_a != 3'd0);
    st_b  = (age_b != 3'd0);
    Stall = IssueValid && !Flush && (st_a || st_b);
    FwdA  = 2'd0;
    FwdB  = 2'd0;
  end
`endif

  always_comb begin
    tbl_d    = '0;
    if (IssueValid && !Stall && !Flush) begin
      tbl_d[0].wrt = IssueRegWrt;
      tbl_d[0].wd  = IssueRegWData;
      tbl_d[0].rd  = IssueRd;
    end
    tbl_d[1] = tbl_q[0];
    tbl_d[2] = tbl_q[1];
    tbl_d[3] = tbl_q[2];
    // squash the two youngest entries; the oldest keeps moving to writeback
    if (Flush) begin
      tbl_d[1].wrt = 1'b0;
      tbl_d[2].wrt = 1'b0;
    end
    cnt_d = cnt_q;
    if (Stall && (cnt_q != 8'hff)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_q <= '0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

  assign WbRegWrt   = tbl_q[3].wrt;
  assign WbRegWData = tbl_q[3].wd;
  assign WbRd       = tbl_q[3].rd;
  assign StallCnt   = cnt_q;

endmodule

// File: tb/tb_regwrite_hazard_ctrl.sv
// Scoreboard bench for regwrite_hazard_ctrl.
// Expected table entries are queued at issue and compared at writeback.
module tb_regwrite_hazard_ctrl;

  typedef struct packed {
    logic       wrt;
    logic [1:0] wd;
    logic [4:0] rd;
  } ent_t;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       IssueValid = 1'b0;
  logic       IssueRegWrt = 1'b0;
  logic [1:0] IssueRegWData = '0;
  logic [4:0] IssueRd = '0;
  logic [4:0] Rn = '0;
  logic [4:0] Rm = '0;
  logic       RnUse = 1'b0;
  logic       RmUse = 1'b0;
  logic       Flush = 1'b0;
  logic       Stall;
  logic [1:0] FwdA, FwdB;
  logic       WbRegWrt;
  logic [1:0] WbRegWData;
  logic [4:0] WbRd;
  logic [7:0] StallCnt;

  int   vec = 0;
  int   errs = 0;
  int   scnt = 0;
  ent_t q[$];

  regwrite_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .IssueValid(IssueValid), .IssueRegWrt(IssueRegWrt),
    .IssueRegWData(IssueRegWData), .IssueRd(IssueRd),
    .Rn(Rn), .Rm(Rm), .RnUse(RnUse), .RmUse(RmUse),
    .Flush(Flush), .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB),
    .WbRegWrt(WbRegWrt), .WbRegWData(WbRegWData), .WbRd(WbRd),
    .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic wrt,
                       input logic [1:0] wd, input logic [4:0] rd,
                       input logic [4:0] rn, input logic rnu,
                       input logic [4:0] rm, input logic rmu,
                       input logic fl);
    IssueValid = v;  IssueRegWrt = wrt;
    IssueRegWData = wd; IssueRd = rd;
    Rn = rn; RnUse = rnu; Rm = rm; RmUse = rmu;
    Flush = fl;
  endtask

  task automatic qreset();
    q.delete();
    repeat (4) q.push_back('0);
    scnt = 0;
  endtask

  // advance one edge; st is the stall the bench expects this cycle
  task automatic tick(input bit st);
    ent_t e, t;
    @(posedge clk);
    e = '0;
    if (IssueValid && !st && !Flush) begin
      e.wrt = IssueRegWrt; e.wd = IssueRegWData; e.rd = IssueRd;
    end
    if (Flush) begin
      t = q[3]; t.wrt = 1'b0; q[3] = t;
      t = q[2]; t.wrt = 1'b0; q[2] = t;
    end
    void'(q.pop_front());
    q.push_back(e);
    if (st && scnt < 255) scnt++;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 2'd1, 5'd3, 5'd3, 1, 5'd0, 0, 0);
    #1;
    vec++; if (Stall !== 1'b0) begin errs++;
      $display("FAIL rst_stall: got %b want 0", Stall); end
    vec++; if (WbRegWrt !== 1'b0) begin errs++;
      $display("FAIL rst_wbwrt: got %b want 0", WbRegWrt); end
    vec++; if (StallCnt !== 8'd0) begin errs++;
      $display("FAIL rst_cnt: got %0d want 0", StallCnt); end
    @(posedge clk); #1;
    vec++; if ({WbRegWrt, WbRegWData, WbRd, FwdA} !== 10'd0) begin errs++;
      $display("FAIL rst_held: got %h want 0", {WbRegWrt, WbRegWData, WbRd, FwdA}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    qreset();
  endtask

  task automatic test_raw();
    int n;
    logic [1:0] ef;
    drive(1, 1, 2'd2, 5'd5, 5'd0, 0, 5'd0, 0, 0);
    #1;
    vec++; if (Stall !== 1'b0) begin errs++;
      $display("FAIL raw_issue: got %b want 0", Stall); end
    tick(0);
    drive(1, 0, 2'd0, 5'd0, 5'd5, 1, 5'd0, 0, 0);
    n = FWD ? 2 : 4;
    for (int i = 0; i <= n; i++) begin
      #1;
      ef = (i == n && FWD) ? 2'd1 : 2'd0;
      vec++; if (Stall !== (i < n)) begin errs++;
        $display("FAIL raw_stall c%0d: got %b want %b", i, Stall, i < n); end
      vec++; if (FwdA !== ef) begin errs++;
        $display("FAIL raw_fwda c%0d: got %0d want %0d", i, FwdA, ef); end
      tick(i < n);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL raw_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
      vec++; if (StallCnt !== scnt[7:0]) begin errs++;
        $display("FAIL raw_cnt c%0d: got %0d want %0d", i, StallCnt, scnt); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick(0);
  endtask

  task automatic test_xzr();
    drive(1, 1, 2'd3, 5'd31, 5'd0, 0, 5'd0, 0, 0);
    #1;
    tick(0);
    drive(1, 0, 2'd0, 5'd0, 5'd31, 1, 5'd31, 1, 0);
    #1;
    vec++; if ({Stall, FwdA, FwdB} !== 5'd0) begin errs++;
      $display("FAIL xzr_hz: got %b want 0", {Stall, FwdA, FwdB}); end
    tick(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL xzr_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
  endtask

  task automatic test_youngest();
    int n;
    logic [1:0] ef;
    drive(1, 1, 2'd1, 5'd7, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(1, 1, 2'd3, 5'd7, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(0, 0, 2'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(1, 0, 2'd0, 5'd0, 5'd0, 0, 5'd7, 1, 0);
    n = FWD ? 1 : 3;
    for (int i = 0; i <= n; i++) begin
      #1;
      ef = (i == n && FWD) ? 2'd1 : 2'd0;
      vec++; if (Stall !== (i < n)) begin errs++;
        $display("FAIL yng_stall c%0d: got %b want %b", i, Stall, i < n); end
      vec++; if (FwdB !== ef) begin errs++;
        $display("FAIL yng_fwdb c%0d: got %0d want %0d", i, FwdB, ef); end
      tick(i < n);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL yng_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick(0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] ef;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'(i), 5'(14 + i), 5'd0, 0, 5'd0, 0, 0);
      #1;
      vec++; if (Stall !== 1'b0) begin errs++;
        $display("FAIL b2b_issue c%0d: got %b want 0", i, Stall); end
      tick(0);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL b2b_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
    drive(1, 1, 2'd1, 5'd18, 5'd15, 1, 5'd14, 1, 0);
    n = FWD ? 0 : 2;
    for (int i = 0; i <= n; i++) begin
      #1;
      ef = (i == n && FWD) ? 4'b0110 : 4'b0000;
      vec++; if (Stall !== (i < n)) begin errs++;
        $display("FAIL b2b_stall c%0d: got %b want %b", i, Stall, i < n); end
      vec++; if ({FwdA, FwdB} !== ef) begin errs++;
        $display("FAIL b2b_fwd c%0d: got %b want %b", i, {FwdA, FwdB}, ef); end
      tick(i < n);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL b2b_drain c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 2'd1, 5'd12, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(1, 1, 2'd2, 5'd10, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(1, 1, 2'd3, 5'd9,  5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    drive(1, 1, 2'd2, 5'd20, 5'd9, 1, 5'd0, 0, 1);
    #1;
    vec++; if (Stall !== 1'b0) begin errs++;
      $display("FAIL fl_stall: got %b want 0", Stall); end
    tick(0);
    drive(1, 0, 2'd0, 5'd0, 5'd9, 1, 5'd10, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      vec++; if ({Stall, FwdA, FwdB} !== 5'd0) begin errs++;
        $display("FAIL fl_after c%0d: got %b want 0", i, {Stall, FwdA, FwdB}); end
      tick(0);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL fl_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 2'd1, 5'(i), 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
    end
    drive(1, 0, 2'd0, 5'd0, 5'd3, 1, 5'd0, 0, 0);
    #1;
    vec++; if (Stall !== 1'b1) begin errs++;
      $display("FAIL mid_pre: got %b want 1", Stall); end
    reset = 1'b0;
    #1;
    vec++; if ({Stall, WbRegWrt, WbRd, StallCnt} !== 15'd0) begin errs++;
      $display("FAIL mid_rst: got %h want 0", {Stall, WbRegWrt, WbRd, StallCnt}); end
    @(posedge clk); #1;
    reset = 1'b1;
    qreset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0);
      vec++; if ({WbRegWrt, WbRegWData, WbRd} !== q[0]) begin errs++;
        $display("FAIL mid_wb c%0d: got %h want %h", i, {WbRegWrt, WbRegWData, WbRd}, q[0]); end
    end
  endtask

  task automatic test_saturation();
    int n;
    n = FWD ? 2 : 4;
    for (int r = 0; r < 150; r++) begin
      drive(1, 1, 2'd0, 5'd20, 5'd0, 0, 5'd0, 0, 0); #1; tick(0);
      drive(1, 0, 2'd0, 5'd0, 5'd20, 1, 5'd0, 0, 0);
      for (int i = 0; i <= n; i++) begin
        #1;
        vec++; if (Stall !== (i < n)) begin errs++;
          $display("FAIL sat_stall r%0d c%0d: got %b want %b", r, i, Stall, i < n); end
        tick(i < n);
        vec++; if (StallCnt !== scnt[7:0]) begin errs++;
          $display("FAIL sat_cnt r%0d c%0d: got %0d want %0d", r, i, StallCnt, scnt); end
      end
    end
    vec++; if (StallCnt !== 8'd255) begin errs++;
      $display("FAIL sat_final: got %0d want 255", StallCnt); end
  endtask

  initial begin
    qreset();
    test_reset();
    test_raw();
    test_xzr();
    test_youngest();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/regwrite_hazard_ctrl.md
REGWRITE_HAZARD_CTRL -- requirements
Module: regwrite_hazard_ctrl

Interface
REQ-001 The block SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 The block SHALL have port: IssueValid  input  1  decode presents an instruction this cycle.
REQ-004 The block SHALL have port: IssueRegWrt  input  1  presented instruction writes the register file.
REQ-005 The block SHALL have port: IssueRegWData  input  2  writeback source select of the presented instruction.
REQ-006 The block SHALL have port: IssueRd  input  5  destination register of the presented instruction.
REQ-007 The block SHALL have ports: Rn, Rm  input  5 each  source registers of the presented instruction.
REQ-008 The block SHALL have ports: RnUse, RmUse  input  1 each  the corresponding source is read.
REQ-009 The block SHALL have port: Flush  input  1  squash the two youngest in-flight entries.
REQ-010 The block SHALL have port: Stall  output  1  presented instruction not accepted this cycle.
REQ-011 The block SHALL have ports: FwdA, FwdB  output  2 each  operand source select for Rn, Rm (0 regfile, 1 age-3 result, 2 age-4 result).
REQ-012 The block SHALL have ports: WbRegWrt  output  1, WbRegWData  output  2, WbRd  output  5  the age-4 entry driving writeback.
REQ-013 The block SHALL have port: StallCnt  output  8  saturating count of stall cycles since reset.

Function
REQ-014 The block SHALL hold a 4-deep in-flight table, ages 1..4, each entry {RegWrt, RegWData, Rd}, shifting one age per cycle.
REQ-015 An entry SHALL be "live" only if its RegWrt=1 and its Rd is not 31 (XZR).
REQ-016 A source SHALL "match" an entry when its Use bit is 1, the entry is live, and the entry Rd equals the source register.
REQ-017 When a source matches several entries, only the youngest (lowest age) match SHALL be considered.
REQ-018 Stall SHALL be combinational: 1 when IssueValid=1 and either source's youngest match requires a stall (per REQ-030/031), else 0.
REQ-019 When IssueValid=1 and Stall=0, age 1 SHALL load {IssueRegWrt, IssueRegWData, IssueRd} on the next edge.
REQ-020 When IssueValid=0 or Stall=1, age 1 SHALL load a bubble {0, 2'd0, 5'd0} on the next edge; older ages keep shifting.
REQ-021 WbRegWrt/WbRegWData/WbRd SHALL equal the age-4 entry, so an accepted instruction appears there exactly 4 cycles after acceptance.
REQ-022 Flush=1 SHALL clear RegWrt of the entries moving into ages 2 and 3 and SHALL force a bubble into age 1, regardless of IssueValid.
REQ-023 Stall SHALL be 0 during a Flush cycle.
REQ-024 FwdA/FwdB SHALL be 0 whenever IssueValid=0, Stall=1, or the source has no match.
REQ-025 StallCnt SHALL increment on each edge where Stall=1 and SHALL hold at 255 (no wrap).
REQ-026 A source equal to 31 SHALL never stall or forward.

Reset
REQ-027 While reset=0, all table entries SHALL be {0, 2'd0, 5'd0} and StallCnt SHALL be 0, immediately and independently of clk.
REQ-028 Consequently, during reset Stall, FwdA, FwdB, WbRegWrt, WbRegWData and WbRd SHALL all be 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; no pending write SHALL survive to WbRegWrt.

Configuration
REQ-030 With macro HAZARD_FWD_EN defined: youngest match at age 1 or 2 SHALL stall; at age 3 SHALL give Fwd=1; at age 4 SHALL give Fwd=2.
REQ-031 Without HAZARD_FWD_EN: a youngest match at any age 1..4 SHALL stall, and FwdA/FwdB SHALL be constant 0.

Verification
REQ-032 Reset check: reset=0 with IssueValid=1, Rn=3, RnUse=1 -> Stall=0, WbRegWrt=0, StallCnt=0.
REQ-033 Back-to-back RAW: accept write Rd=5, next cycle Rn=5 RnUse=1 -> Stall=1 for 2 cycles then Fwd A=1 (FWD_EN), or Stall=1 for 4 cycles then FwdA=0 (no FWD_EN); Rd=5 reaches WbRd 4 cycles after acceptance.
REQ-034 XZR: accept write Rd=31, then Rn=31 RnUse=1 -> Stall=0, FwdA=0.
REQ-035 Youngest priority (FWD_EN): writes Rd=7 accepted at t and t+1 idle-free, issue Rm=7 at t+3 -> youngest match age 2 -> Stall=1, not Fwd=2.
REQ-036 Flush: accept Rd=9, next cycle Flush=1 with Rn=9 -> Stall=0; thereafter Rn=9 never stalls and WbRegWrt stays 0 for that slot.
REQ-037 Saturation: hold a stalling source 300 cycles -> StallCnt reads 255 and stays 255.
